// File: rtl/uni_shift_reg.sv
// rtl/uni_shift_reg.sv - universal shift register with frame counting
//
// Purpose:
//   WIDTH-bit register that can hold, shift left, shift right or parallel
//   load. Shifts either take a serial bit from data_in or rotate the
//   register onto itself (ROTATE=1). Every shift edge advances a frame
//   counter, and the WIDTH-th shift of a frame raises a one-cycle
//   frame_done pulse. A parallel load abandons the current frame.
//
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   mode        in   2      00 hold, 01 shift left, 10 shift right, 11 load
//   data_in     in   1      serial input for shifts (unused when ROTATE=1)
//   par_in      in   WIDTH  parallel load value
//   data_out    out  WIDTH  registered register contents
//   so_msb      out  1      data_out[WIDTH-1], left-shift serial output
//   so_lsb      out  1      data_out[0], right-shift serial output
//   bit_cnt     out  CNT_W  shifts completed in the current frame
//   frame_done  out  1      registered pulse after the WIDTH-th shift
module uni_shift_reg #(
  parameter int WIDTH  = 8,
  parameter int ROTATE = 0,
  parameter int CNT_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             data_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] data_out,
  output logic             so_msb,
  output logic             so_lsb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  mode_e mode_s;
  logic  left_in;
  logic  right_in;
  logic  shift_en;

  assign mode_s = mode_e'(mode);

  // In rotate mode the bit falling off one end re-enters at the other.
  assign left_in  = (ROTATE != 0) ? data_q[WIDTH-1] : data_in;
  assign right_in = (ROTATE != 0) ? data_q[0]       : data_in;

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_en = 1'b0;

    unique case (mode_s)
      MODE_HOLD: begin
        data_d = data_q;
      end
      MODE_LEFT: begin
        data_d   = {data_q[WIDTH-2:0], left_in};
        shift_en = 1'b1;
      end
      MODE_RIGHT: begin
        data_d   = {right_in, data_q[WIDTH-1:1]};
        shift_en = 1'b1;
      end
      MODE_LOAD: begin
        data_d = par_in;
        cnt_d  = '0;
      end
      default: begin
        data_d = data_q;
      end
    endcase

    // Both directions count toward one frame; the last shift wraps the
    // counter straight to 0 so back-to-back frames have no gap.
    if (shift_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign data_out   = data_q;
  assign bit_cnt    = cnt_q;
  assign frame_done = done_q;

  // Serial outputs tap the register directly, no extra stage.
  assign so_msb = data_q[WIDTH-1];
  assign so_lsb = data_q[0];

endmodule

// File: tb/tb_uni_shift_reg.sv
// tb/tb_uni_shift_reg.sv - self-checking bench for uni_shift_reg
module tb_uni_shift_reg;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        data_in = 1'b0;
  logic [63:0] par_all = 64'd0;

  logic [63:0] dout_w [NI];
  logic [63:0] cnt_w  [NI];
  logic        done_w [NI];
  logic        msb_w  [NI];
  logic        lsb_w  [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int wd(int i);
    return (i % 3 == 0) ? 2 : ((i % 3 == 1) ? 8 : 13);
  endfunction

  function automatic int rt(int i);
    return i / 3;
  endfunction

  // Instances: 0..2 = WIDTH 2/8/13 shifting data_in, 3..5 = same widths rotating.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g % 3 == 0) ? 2 : ((g % 3 == 1) ? 8 : 13);
    localparam int R = g / 3;
    logic [W-1:0]          dout;
    logic [$clog2(W)-1:0]  cnt;
    logic                  done, msb, lsb;
    uni_shift_reg #(.WIDTH(W), .ROTATE(R)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .data_in    (data_in),
      .par_in     (par_all[W-1:0]),
      .data_out   (dout),
      .so_msb     (msb),
      .so_lsb     (lsb),
      .bit_cnt    (cnt),
      .frame_done (done)
    );
    assign dout_w[g] = 64'(dout);
    assign cnt_w[g]  = 64'(cnt);
    assign done_w[g] = done;
    assign msb_w[g]  = msb;
    assign lsb_w[g]  = lsb;
  end

  // Reference model: register value as an integer, frame position derived
  // from the total number of shifts since the last load/reset.
  logic [63:0] m_data   [NI] = '{default: 64'd0};
  int          m_shifts [NI] = '{default: 0};
  logic        m_done   [NI] = '{default: 1'b0};

  function automatic logic [63:0] nxt(logic [63:0] v, int w, int r, logic [1:0] m,
                                      logic d, logic [63:0] p);
    logic [63:0] mask;
    logic        s;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (m)
      2'b01: begin
        s = (r != 0) ? v[w-1] : d;
        return ((v << 1) | 64'(s)) & mask;
      end
      2'b10: begin
        s = (r != 0) ? v[0] : d;
        return (v >> 1) | (64'(s) << (w - 1));
      end
      2'b11: return p & mask;
      default: return v;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_data[i]   <= 64'd0;
        m_shifts[i] <= 0;
        m_done[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_data[i] <= nxt(m_data[i], wd(i), rt(i), mode, data_in, par_all);
        if (mode == 2'b11) begin
          m_shifts[i] <= 0;
          m_done[i]   <= 1'b0;
        end else if (mode == 2'b01 || mode == 2'b10) begin
          m_shifts[i] <= m_shifts[i] + 1;
          m_done[i]   <= ((m_shifts[i] + 1) % wd(i)) == 0;
        end else begin
          m_done[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    logic [63:0] md;
    for (int i = 0; i < NI; i++) begin
      md = m_data[i];
      chk($sformatf("model inst%0d data_out", i), dout_w[i], md);
      chk($sformatf("model inst%0d bit_cnt", i), cnt_w[i], 64'(m_shifts[i] % wd(i)));
      chk($sformatf("model inst%0d frame_done", i), 64'(done_w[i]), 64'(m_done[i]));
      chk($sformatf("model inst%0d so_msb", i), 64'(msb_w[i]), 64'(md[wd(i)-1]));
      chk($sformatf("model inst%0d so_lsb", i), 64'(lsb_w[i]), 64'(md[0]));
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic d, input logic [63:0] p);
    mode    = m;
    data_in = d;
    par_all = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic [1:0] m;
    logic       d;
    logic [7:0] p;
    logic       chk_pre;
    logic       pre_msb;
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vq[$];

  task automatic av(input logic [1:0] m, input logic d, input logic [7:0] p,
                    input logic cp, input logic pm, input logic [7:0] ed,
                    input logic [2:0] ec, input logic edn);
    vec_t v;
    v = '{m: m, d: d, p: p, chk_pre: cp, pre_msb: pm, exp_data: ed, exp_cnt: ec, exp_done: edn};
    vq.push_back(v);
  endtask

  initial begin
    vec_t v;

    // Left frame: load 0xA5, eight left shifts of 1.
    av(2'b11, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b1, 8'h4B, 3'd1, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b0, 8'h97, 3'd2, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b1, 8'h2F, 3'd3, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b0, 8'h5F, 3'd4, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b0, 8'hBF, 3'd5, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b1, 8'h7F, 3'd6, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF, 3'd7, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b1);
    av(2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0);
    // Right shift of 0x81 with data_in=0.
    av(2'b11, 1'b0, 8'h81, 1'b0, 1'b0, 8'h81, 3'd0, 1'b0);
    av(2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 3'd1, 1'b0);
    // Holds and mixed directions, then a 9th back-to-back shift.
    av(2'b11, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h0F, 3'd0, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h1E, 3'd1, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 3'd2, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h78, 3'd3, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'hF0, 3'd4, 1'b0);
    av(2'b00, 1'b1, 8'h00, 1'b0, 1'b0, 8'hF0, 3'd4, 1'b0);
    av(2'b00, 1'b1, 8'h00, 1'b0, 1'b0, 8'hF0, 3'd4, 1'b0);
    av(2'b00, 1'b1, 8'h00, 1'b0, 1'b0, 8'hF0, 3'd4, 1'b0);
    av(2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 8'hF8, 3'd5, 1'b0);
    av(2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFC, 3'd6, 1'b0);
    av(2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFE, 3'd7, 1'b0);
    av(2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b1);
    av(2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7F, 3'd1, 1'b0);
    // Load abort at bit_cnt=5, then a full fresh frame.
    av(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 3'd1, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b0, 1'b0, 8'h03, 3'd2, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b0, 1'b0, 8'h07, 3'd3, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b0, 1'b0, 8'h0F, 3'd4, 1'b0);
    av(2'b01, 1'b1, 8'h00, 1'b0, 1'b0, 8'h1F, 3'd5, 1'b0);
    av(2'b11, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 3'd0, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h78, 3'd1, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'hF0, 3'd2, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE0, 3'd3, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 3'd4, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 3'd5, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd6, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd7, 1'b0);
    av(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);

    // Reset state, asserted asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset data_out", dout_w[1], 64'h0);
    chk("reset bit_cnt", cnt_w[1], 64'h0);
    chk("reset frame_done", 64'(done_w[1]), 64'h0);
    check_model();
    v = vq[0];
    drive(v.m, v.d, 64'(v.p));
    #1 rst_n = 1'b1;

    // Directed table on the WIDTH=8, ROTATE=0 instance.
    foreach (vq[k]) begin
      v = vq[k];
      if (v.chk_pre) chk($sformatf("vec%0d so_msb before shift", k), 64'(msb_w[1]), 64'(v.pre_msb));
      drive(v.m, v.d, 64'(v.p));
      step();
      chk($sformatf("vec%0d data_out", k), dout_w[1], 64'(v.exp_data));
      chk($sformatf("vec%0d bit_cnt", k), cnt_w[1], 64'(v.exp_cnt));
      chk($sformatf("vec%0d frame_done", k), 64'(done_w[1]), 64'(v.exp_done));
      chk($sformatf("vec%0d so_lsb", k), 64'(lsb_w[1]), 64'(v.exp_data[0]));
    end

    // Reset mid-frame at bit_cnt=5.
    drive(2'b11, 1'b0, 64'h5A);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 1'b1, 64'h0);
      step();
    end
    chk("midreset pre bit_cnt", cnt_w[1], 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset data_out", dout_w[1], 64'h0);
    chk("midreset bit_cnt", cnt_w[1], 64'h0);
    chk("midreset frame_done", 64'(done_w[1]), 64'h0);
    chk("midreset so_msb", 64'(msb_w[1]), 64'h0);
    chk("midreset so_lsb", 64'(lsb_w[1]), 64'h0);
    check_model();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("postreset shift%0d frame_done", i + 1), 64'(done_w[1]), 64'h0);
      chk($sformatf("postreset shift%0d bit_cnt", i + 1), cnt_w[1], 64'(i + 1));
    end
    step();
    chk("postreset full frame_done", 64'(done_w[1]), 64'h1);

    // Rotate on the WIDTH=8, ROTATE=1 instance; data_in held low to show it is ignored.
    drive(2'b11, 1'b0, 64'h81);
    step();
    chk("rot load", dout_w[4], 64'h81);
    drive(2'b01, 1'b0, 64'h0);
    step();
    chk("rot first shift", dout_w[4], 64'h03);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rot shift%0d frame_done", i + 2), 64'(done_w[4]), 64'h0);
    end
    step();
    chk("rot eighth shift data_out", dout_w[4], 64'h81);
    chk("rot eighth shift frame_done", 64'(done_w[4]), 64'h1);
    drive(2'b00, 1'b0, 64'h0);
    step();
    chk("rot pulse one cycle", 64'(done_w[4]), 64'h0);

    // Random stimulus against the model, with occasional async resets.
    for (int n = 0; n < 2400; n++) begin
      int r;
      logic [1:0] m;
      r = int'($urandom_range(0, 15));
      if (r == 0) m = 2'b11;
      else if (r < 4) m = 2'b00;
      else m = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      drive(m, 1'($urandom_range(0, 1)), {$urandom(), $urandom()});
      step();
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_model();
        #1 rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uni_shift_reg.md
UNI_SHIFT_REG -- requirements
Module: uni_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register length in bits; legal range 2..64.
REQ-002 Parameter ROTATE, default 0; when 1, shifts rotate and data_in is ignored; when 0, shifts take data_in.
REQ-003 Parameter CNT_W, default $clog2(WIDTH), bit_cnt width; SHALL be at least 1.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 data_in  input  1  serial input bit, used by shifts when ROTATE=0.
REQ-008 par_in  input  WIDTH  parallel load value.
REQ-009 data_out  output  WIDTH  register contents, registered.
REQ-010 so_msb  output  1  combinational copy of data_out[WIDTH-1], the left-shift serial output.
REQ-011 so_lsb  output  1  combinational copy of data_out[0], the right-shift serial output.
REQ-012 bit_cnt  output  CNT_W  shifts completed in the current frame, 0..WIDTH-1, registered.
REQ-013 frame_done  output  1  one-cycle registered pulse marking completion of WIDTH shifts.

Function
REQ-014 Hold (00): data_out and bit_cnt SHALL keep their values; frame_done SHALL be 0 the following cycle.
REQ-015 Shift left (01): data_out SHALL become {data_out[WIDTH-2:0], s}, where s = data_in if ROTATE=0 and s = data_out[WIDTH-1] if ROTATE=1.
REQ-016 Shift right (10): data_out SHALL become {s, data_out[WIDTH-1:1]}, where s = data_in if ROTATE=0 and s = data_out[0] if ROTATE=1.
REQ-017 Load (11): data_out SHALL become par_in; bit_cnt SHALL become 0; frame_done SHALL be 0 the following cycle.
REQ-018 Each shift edge SHALL advance bit_cnt by 1; left and right shifts both count toward the same frame.
REQ-019 A shift edge with bit_cnt = WIDTH-1 SHALL wrap bit_cnt to 0 and SHALL drive frame_done to 1 for exactly the next cycle.
REQ-020 Consecutive frames of back-to-back shifts SHALL produce one frame_done pulse every WIDTH cycles, with no dead cycle between frames.
REQ-021 Hold cycles inside a frame SHALL NOT alter the count; frame_done SHALL follow only the WIDTH-th shift edge.
REQ-022 Load at any bit_cnt SHALL abort the frame: no frame_done for that frame, and counting restarts at 0.
REQ-023 Latency: the effect of any mode SHALL be visible on data_out, bit_cnt and frame_done one rising edge after it is sampled.
REQ-024 so_msb and so_lsb SHALL follow data_out with no extra register stage.
REQ-025 mode, data_in and par_in SHALL be sampled only on the rising clk edge; no input SHALL combinationally affect any output.

Reset
REQ-026 rst_n low SHALL immediately force data_out=0, bit_cnt=0 and frame_done=0, independent of clk; so_msb and so_lsb SHALL follow to 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no frame_done SHALL issue for it.
REQ-028 After rst_n deasserts, the first rising edge SHALL perform normal operation for the sampled mode.

Verification
REQ-029 The bench SHALL cover these directed scenarios (WIDTH=8 unless stated):
- Reset mid-frame: at bit_cnt=5, pulse rst_n low between clk edges -> data_out=0x00, bit_cnt=0, frame_done=0 before the next edge; no later frame_done for that frame.
- Left frame: load 0xA5, then 8 left shifts with data_in=1 -> so_msb sequence before each shift 1,0,1,0,0,1,0,1; data_out=0xFF; frame_done high exactly one cycle after the 8th shift edge.
- Right shift: load 0x81, then 1 right shift with data_in=0 -> data_out=0x40, bit_cnt=1, so_lsb=0.
- Rotate (ROTATE=1): load 0x81; 1 left shift -> 0x03; 7 more left shifts -> 0x81 and frame_done pulse.
- Holds and mixed directions: 4 left shifts, 3 holds, 4 right shifts -> bit_cnt stays 4 through the holds; frame_done only after the 8th shift; a 9th back-to-back shift gives bit_cnt=1, frame_done=0.
- Load abort: load at bit_cnt=5 -> bit_cnt=0, no frame_done; the next frame_done requires 8 further shifts.
REQ-030 The bench SHALL check every output against a cycle-accurate reference model each cycle, under random mode and data_in for at least 2000 cycles with WIDTH in {2, 8, 13} and ROTATE in {0, 1}.
